// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: request, response and ALU-side signals of the shared-ALU controller; slave = controller, master = environment
interface alu_share_ctrl_if #(parameter int WIDTH = 40);
  logic             req0_valid, req0_ready;
  logic [4:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [4:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [4:0]       alu_s;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_s,
    input  alu_out,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_s,
    output alu_out,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one registered ALU between two requesters (ports: clk, rst_n, bus slave modport)
module alu_share_ctrl #(
  parameter int WIDTH = 40,
  parameter int LAT   = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_share_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d, id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]       alu_s_q, alu_s_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d, rsp_id_q, rsp_id_d;
  logic             grant, accept, bad;
  logic [4:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  // on a tie the requester that did not win last time gets the grant
  assign grant  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign sel_op = grant ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant ? bus.req1_a : bus.req0_a;
  assign sel_b  = grant ? bus.req1_b : bus.req0_b;
  assign bad    = !(sel_op inside {5'b00101, 5'b00110, 5'b01000, 5'b01011}) ||
                  (sel_op == 5'b01011 && sel_b == '0);
  assign accept = bus.req0_ready || bus.req1_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_s_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_s_q      <= alu_s_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (bad ? RESP : ISSUE) : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = cnt_q == CW'(LAT - 1) ? RESP : WAIT;
      default: state_d = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  // operands reach the ALU only for legal ops; the opcode is live for the ISSUE cycle alone
  always_comb begin
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_s_d      = alu_s_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;
    if (state_q == IDLE && accept) begin
      last_grant_d = grant;
      id_d         = grant;
      if (bad) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        rsp_id_d   = grant;
      end else begin
        alu_a_d = sel_a;
        alu_b_d = sel_b;
        alu_s_d = sel_op;
      end
    end
    if (state_q == ISSUE) begin
      alu_s_d = '0;
      cnt_d   = '0;
    end
    if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(LAT - 1)) begin
        rsp_data_d = bus.alu_out;
        rsp_err_d  = 1'b0;
        rsp_id_d   = id_q;
      end
    end
  end
  always_comb begin
    bus.req0_ready = state_q == IDLE && bus.req0_valid && !grant;
    bus.req1_ready = state_q == IDLE && bus.req1_valid && grant;
    bus.rsp_valid  = state_q == RESP;
    bus.rsp_data   = rsp_data_q;
    bus.rsp_err    = rsp_err_q;
    bus.rsp_id     = rsp_id_q;
    bus.alu_a      = alu_a_q;
    bus.alu_b      = alu_b_q;
    bus.alu_s      = alu_s_q;
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vector bench for alu_share_ctrl with a registered ALU model
module tb_alu_share_ctrl;
  localparam int W = 40;
  typedef struct {
    logic         id;
    logic [4:0]   op;
    logic [W-1:0] a, b, data;
    logic         err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] alu_q = '0;
  vec_t vt [9];
  always #5 clk = ~clk;
  alu_share_ctrl_if #(.WIDTH(W)) bus();
  alu_share_ctrl #(.WIDTH(W), .LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk) begin
    case (bus.alu_s)
      5'b00101: alu_q <= bus.alu_a + bus.alu_b;
      5'b00110: alu_q <= bus.alu_a - bus.alu_b;
      5'b01000: alu_q <= bus.alu_a * bus.alu_b;
      5'b01011: alu_q <= bus.alu_b != '0 ? bus.alu_a / bus.alu_b : '0;
      default:  alu_q <= alu_q;
    endcase
  end
  assign bus.alu_out = alu_q;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_req(input logic id, input logic v, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic do_op(input vec_t v);
    int lat;
    @(negedge clk);
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    bus.rsp_ready = 1'b1;
    #1;
    chk("vec_ready", v.id ? bus.req1_ready : bus.req0_ready, 1);
    chk("vec_other_ready", v.id ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk);
    set_req(v.id, 1'b0, 5'b0, '0, '0);
    chk("vec_alu_s", bus.alu_s, v.err ? 5'b0 : v.op);
    wait_rsp(lat);
    chk("vec_latency", lat, v.err ? 1 : 3);
    chk("vec_id", bus.rsp_id, v.id);
    chk("vec_data", bus.rsp_data, v.data);
    chk("vec_err", bus.rsp_err, v.err);
    @(negedge clk);
    chk("vec_valid_drop", bus.rsp_valid, 0);
  endtask
  initial begin
    int lat, n;
    vt[0] = '{1'b0, 5'b00101, 40'h0b, 40'h03, 40'h0e, 1'b0};
    vt[1] = '{1'b0, 5'b00110, 40'h0b, 40'h03, 40'h08, 1'b0};
    vt[2] = '{1'b0, 5'b01000, 40'h0b, 40'h03, 40'h21, 1'b0};
    vt[3] = '{1'b0, 5'b01011, 40'h0b, 40'h03, 40'h03, 1'b0};
    vt[4] = '{1'b1, 5'b00110, 40'h00, 40'h01, 40'hFFFFFFFFFF, 1'b0};
    vt[5] = '{1'b1, 5'b01011, 40'h0b, 40'h00, 40'h00, 1'b1};
    vt[6] = '{1'b0, 5'b00111, 40'h0b, 40'h03, 40'h00, 1'b1};
    vt[7] = '{1'b1, 5'b01000, 40'h1000000000, 40'h111, 40'h1000000000, 1'b0};
    vt[8] = '{1'b1, 5'b01011, 40'hff, 40'h10, 40'h0f, 1'b0};
    set_req(1'b0, 1'b0, 5'b0, '0, '0);
    set_req(1'b1, 1'b0, 5'b0, '0, '0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_alu_s", bus.alu_s, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_id", bus.rsp_id, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // both requesters valid continuously: grants alternate starting with 0
    @(negedge clk);
    set_req(1'b0, 1'b1, 5'b00101, 40'd1, 40'd1);
    set_req(1'b1, 1'b1, 5'b00101, 40'd10, 40'd20);
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(bus.req0_ready || bus.req1_ready) && n < 12) begin
        @(negedge clk);
        n++;
      end
      if (i > 0) chk("rr_spacing", n, 0);
      chk("rr_grant", bus.req1_ready, i % 2);
      chk("rr_one_ready", bus.req0_ready && bus.req1_ready, 0);
      @(negedge clk);
      if (i == 3) begin
        set_req(1'b0, 1'b0, 5'b0, '0, '0);
        set_req(1'b1, 1'b0, 5'b0, '0, '0);
      end
      wait_rsp(lat);
      chk("rr_latency", lat, 3);
      chk("rr_id", bus.rsp_id, i % 2);
      chk("rr_data", bus.rsp_data, (i % 2) ? 30 : 2);
      @(negedge clk);
    end
    chk("rr_idle", bus.rsp_valid, 0);
    for (int i = 0; i < 9; i++) do_op(vt[i]);
    // backpressure: response must hold while rsp_ready is low
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 5'b00101, 40'd5, 40'd6);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'b0, '0, '0);
    wait_rsp(lat);
    chk("bp_latency", lat, 3);
    set_req(1'b1, 1'b1, 5'b00101, 40'd1, 40'd1);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, 40'h0b);
      chk("bp_id", bus.rsp_id, 0);
      chk("bp_readys", bus.req0_ready || bus.req1_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 1'b0, 5'b0, '0, '0);
    @(negedge clk);
    chk("bp_release", bus.rsp_valid, 0);
    // asynchronous reset during WAIT abandons the operation
    @(negedge clk);
    set_req(1'b0, 1'b1, 5'b01000, 40'd7, 40'd6);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'b0, '0, '0);
    @(negedge clk);
    chk("wait_alu_s", bus.alu_s, 0);
    chk("wait_valid", bus.rsp_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.rsp_valid, 0);
    chk("arst_alu_a", bus.alu_a, 0);
    chk("arst_alu_b", bus.alu_b, 0);
    chk("arst_data", bus.rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_rsp", bus.rsp_valid, 0);
    set_req(1'b0, 1'b1, 5'b00101, 40'd1, 40'd2);
    set_req(1'b1, 1'b1, 5'b00101, 40'd3, 40'd4);
    #1;
    chk("arst_tie_r0", bus.req0_ready, 1);
    chk("arst_tie_r1", bus.req1_ready, 0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'b0, '0, '0);
    set_req(1'b1, 1'b0, 5'b0, '0, '0);
    wait_rsp(lat);
    chk("arst_latency", lat, 3);
    chk("arst_id", bus.rsp_id, 0);
    chk("arst_data_after", bus.rsp_data, 3);
    @(negedge clk);
    chk("arst_drop", bus.rsp_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
